// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction-fetch queue: default sizes, the FIFO entry layout and the FSM states.
package ifq_pkg;

    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_DW    = 32;

    typedef struct packed {
        logic [IFQ_DW-1:0] pc;
        logic [IFQ_DW-1:0] instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetch entries with occupancy count and a synchronous clear.
// Latency: a pushed entry reaches the head output on the cycle after the write edge.
// Backpressure: none internally; push while full without a pop is dropped, clear overrides push and pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int W     = $bits(ifq_entry_t)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~clear & (count_q != '0);
        do_push  = push & ~clear & ((count_q != (AW+1)'(DEPTH)) | do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch: issues imem reads from pc_in and queues {pc, instr} for decode (IFETCH_QUEUE_BYPASS_EN adds empty-queue bypass).
// Latency: issue in N, out_valid in N+2 (N+1 with bypass).
// Backpressure: issue only while queued + in-flight entries fit after this cycle's pop; pc_advance follows issue.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int DW    = IFQ_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DW-1:0]          pc_in,
    output logic                   pc_advance,
    output logic                   imem_req,
    output logic [DW-1:0]          imem_addr,
    input  logic [DW-1:0]          imem_rdata,
    input  logic                   flush,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_instr,
    output logic [DW-1:0]          out_pc,
    output logic [$clog2(DEPTH):0] out_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    ifq_state_e    state_q, state_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] inflight_pc_q, inflight_pc_d;

    entry_t        push_ent, head_ent;
    logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          ret, wr_ret, pop, issue;
    logic [CW:0]   occ;
`ifdef IFETCH_QUEUE_BYPASS_EN
    logic          byp;
`endif

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .head_dat (head_ent),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        ret = inflight_q & ~flush;
`ifdef IFETCH_QUEUE_BYPASS_EN
        // Returning data is shown directly when nothing older is queued.
        byp       = ret & fifo_empty;
        out_valid = ~fifo_empty | byp;
        out_pc    = fifo_empty ? (byp ? inflight_pc_q : '0) : head_ent.pc;
        out_instr = fifo_empty ? (byp ? imem_rdata : '0) : head_ent.instr;
        wr_ret    = ret & ~(byp & out_ready);
`else
        out_valid = ~fifo_empty;
        out_pc    = fifo_empty ? '0 : head_ent.pc;
        out_instr = fifo_empty ? '0 : head_ent.instr;
        wr_ret    = ret;
`endif
        pop       = out_valid & out_ready;
        fifo_pop  = pop & ~fifo_empty;
        fifo_push = wr_ret & (~fifo_full | fifo_pop);
        push_ent  = '{pc: inflight_pc_q, instr: imem_rdata};
        // The in-flight fetch already owns a slot, so it counts against capacity.
        occ       = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue     = (state_q == ST_RUN) & ~halt & ~flush & (occ < (CW+1)'(DEPTH));
    end

    always_comb begin
        state_d       = state_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_in : inflight_pc_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt & ~flush) state_d = ST_HALTED;
            ST_HALTED: if (flush | ~halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_req   = issue;
    assign pc_advance = issue;
    assign imem_addr  = pc_in;
    assign out_count  = fifo_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: PC model (+4 on pc_advance, redirect on flush), imem returning addr ^ A5A50000.
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in;
    logic        pc_advance, imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        flush = 1'b0, halt = 1'b0, out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr, out_pc;
    logic [2:0]  out_count;
    logic [31:0] redir_pc = 32'h0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .halt       (halt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_count  (out_count)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset)          pc_in <= 32'h0;
        else if (flush)      pc_in <= redir_pc;
        else if (pc_advance) pc_in <= pc_in + 32'd4;
    end

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
    end

    // Reference model: ordered list of fetched PCs awaiting decode plus one pending fetch.
    int unsigned total = 0, bad = 0;
    logic [31:0] mq[$];
    bit          booted, halted, pend_v;
    logic [31:0] pend_pc, s_pc;
    bit          e_pop, e_iss, s_flush, s_halt;

    typedef struct {
        int rdy; int req; int addr; int vld; int pc; int cnt;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        booted  = 1'b0;
        halted  = 1'b0;
        pend_v  = 1'b0;
        pend_pc = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; halt = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic drive(input bit r, input bit h, input bit f, input logic [31:0] rd);
        out_ready = r; halt = h; flush = f; redir_pc = rd;
        #1;
    endtask

    task automatic model_check();
        int occ;
        e_pop   = (mq.size() != 0) && out_ready;
        occ     = mq.size() + int'(pend_v) - int'(e_pop);
        e_iss   = booted && !halted && !halt && !flush && (occ < DEPTH);
        s_flush = flush;
        s_halt  = halt;
        s_pc    = pc_in;
        chk("imem_req", 32'(imem_req), 32'(e_iss));
        chk("pc_advance", 32'(pc_advance), 32'(e_iss));
        if (e_iss) chk("imem_addr", imem_addr, pc_in);
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_count", 32'(out_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_instr", out_instr, mq[0] ^ KEY);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (!booted) begin
            booted = 1'b1;
        end else begin
            halted = !s_flush && s_halt;
            if (s_flush) begin
                mq.delete();
                pend_v = 1'b0;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (pend_v) mq.push_back(pend_pc);
                pend_v  = e_iss;
                pend_pc = s_pc;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit h, input bit f, input logic [31:0] rd);
        drive(r, h, f, rd);
        model_check();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          first_req, first_vld, nreq, hcnt;
        bit          found, saw_last;
        logic [31:0] last_iss, held_pc;
        logic [31:0] got[$];

        // Ready held low from reset: four fetches fill the queue, then drain in order.
        tbl[0] = '{0, 0, 0,  0, 0,  0};
        tbl[1] = '{0, 1, 0,  0, 0,  0};
        tbl[2] = '{0, 1, 4,  0, 0,  0};
        tbl[3] = '{0, 1, 8,  1, 0,  1};
        tbl[4] = '{0, 1, 12, 1, 0,  2};
        tbl[5] = '{0, 0, 0,  1, 0,  3};
        for (int i = 6; i < 12; i++) tbl[i] = '{0, 0, 0, 1, 0, 4};
        tbl[12] = '{1, 1, 16, 1, 0,  4};
        tbl[13] = '{1, 1, 20, 1, 4,  3};
        tbl[14] = '{1, 1, 24, 1, 8,  3};
        tbl[15] = '{1, 1, 28, 1, 12, 3};
        tbl[16] = '{1, 1, 32, 1, 16, 3};

        reset = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(out_count), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_adv", 32'(pc_advance), 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rdy != 0, 1'b0, 1'b0, 32'h0);
            model_check();
            chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req != 0) chk("tbl_addr", imem_addr, 32'(tbl[i].addr));
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].vld));
            chk("tbl_count", 32'(out_count), 32'(tbl[i].cnt));
            if (tbl[i].vld != 0) begin
                chk("tbl_pc", out_pc, 32'(tbl[i].pc));
                chk("tbl_instr", out_instr, 32'(tbl[i].pc) ^ KEY);
            end
            advance();
        end

        // Streaming from reset with ready high.
        do_reset();
        first_req = -1; first_vld = -1;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            model_check();
            if (imem_req && first_req < 0) first_req = k;
            if (out_valid) begin
                if (first_vld < 0) first_vld = k;
                got.push_back(out_pc);
            end
            advance();
        end
        chk("boot_first_req", 32'(first_req), 32'd1);
        chk("first_latency", 32'(first_vld - first_req), 32'd2);
        chk("stream_len", 32'(got.size() >= 4), 32'd1);
        if (got.size() >= 4)
            for (int i = 0; i < 4; i++) chk("stream_pc", got[i], 32'(4 * i));

        // Flush with three queued and one in flight, redirect to 0x100.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        chk("pre_flush_count", 32'(out_count), 32'd3);
        model_check();
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("flush_count", 32'(out_count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_resume_addr", imem_addr, 32'h100);
        model_check();
        advance();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            model_check();
            if (out_valid) begin
                found = 1'b1;
                chk("flush_first_pc", out_pc, 32'h100);
            end
            advance();
        end
        if (!found) chk("flush_timeout", 32'd0, 32'd1);

        // Halt for five cycles mid-stream.
        do_reset();
        last_iss = 32'h0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            model_check();
            if (imem_req) last_iss = imem_addr;
            advance();
        end
        nreq = 0; saw_last = 1'b0;
        held_pc = pc_in;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            model_check();
            if (imem_req) nreq++;
            if (out_valid && out_pc == last_iss) saw_last = 1'b1;
            advance();
        end
        chk("halt_no_req", 32'(nreq), 32'd0);
        chk("halt_inflight_delivered", 32'(saw_last), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            model_check();
            if (imem_req) begin
                found = 1'b1;
                chk("halt_resume_addr", imem_addr, held_pc);
            end
            advance();
        end
        if (!found) chk("halt_resume_timeout", 32'd0, 32'd1);

        // Asynchronous reset with two entries buffered and one in flight.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_count", 32'(out_count), 32'd2);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_count", 32'(out_count), 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_adv", 32'(pc_advance), 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_instr", out_instr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        model_check();
        advance();
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic against the model.
        do_reset();
        hcnt = 0;
        for (int k = 0; k < 700; k++) begin
            bit r, h, f;
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 24) == 0);
            if (hcnt > 0) begin
                hcnt--;
                h = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                hcnt = $urandom_range(1, 6);
                h = 1'b1;
            end else begin
                h = 1'b0;
            end
            cyc(r, h, f, 32'($urandom_range(0, 1023)) << 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
